// File: rtl/decode_scoreboard_if.sv
// Decode-to-scoreboard interface: instruction hazard fields, register-file
// writeback port, flush, and the scoreboard's issue decision back to decode.
//
// Handshake: iValid is the request from decode. !oStall is the ready that
// comes back in the same cycle. oIssue is iValid && ready && !iFlush, and
// the instruction moves to execute only in a cycle where oIssue is high.
// Decode must hold its fields stable while oStall is high.
interface decode_scoreboard_if;
    logic        iValid;
    logic [4:0]  iSrc0Addr;
    logic [4:0]  iSrc1Addr;
    logic        iSrc0En;
    logic        iSrc1En;
    logic [4:0]  iWriteAddr;
    logic        iWriteEn;
    logic        iMduOp;
    logic [4:0]  iWbAddr;
    logic        iWbEn;
    logic        iFlush;
    logic        oStall;
    logic        oIssue;
    logic        oMduBusy;
    logic [31:0] oPending;

    // Decode side and control decoder
    modport master (
        output iValid, iSrc0Addr, iSrc1Addr, iSrc0En, iSrc1En,
               iWriteAddr, iWriteEn, iMduOp, iWbAddr, iWbEn, iFlush,
        input  oStall, oIssue, oMduBusy, oPending
    );

    // Scoreboard side
    modport slave (
        input  iValid, iSrc0Addr, iSrc1Addr, iSrc0En, iSrc1En,
               iWriteAddr, iWriteEn, iMduOp, iWbAddr, iWbEn, iFlush,
        output oStall, oIssue, oMduBusy, oPending
    );
endinterface

// File: rtl/decode_scoreboard.sv
// Decode-stage issue controller. Tracks in-flight register writes (one
// pending bit per register, r0 included), the MDU busy counter, and a
// two-deep history of the youngest issued writers so a mispredict flush
// can retract their pending bits.
// Optional feature macro: SCOREBOARD_BYPASS_EN -- a same-cycle writeback
// clears a hazard combinationally (register file writes before it reads).
module decode_scoreboard #(
    parameter int MDU_LATENCY = 4
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    decode_scoreboard_if.slave    bus
);

    localparam logic [3:0] MDU_LOAD = 4'(MDU_LATENCY);

    logic [31:0] pending_q, pending_d;
    logic [3:0]  mdu_cnt_q, mdu_cnt_d;
    logic        h0_valid_q, h0_valid_d;
    logic [4:0]  h0_addr_q, h0_addr_d;
    logic        h1_valid_q, h1_valid_d;
    logic [4:0]  h1_addr_q, h1_addr_d;

    logic [31:0] pending_eff;
    logic        raw0, raw1, waw, structural;
    logic        stall, issue;

    // Hazard detection and the issue decision, gated off during reset
    always_comb begin
        pending_eff = pending_q;
`ifdef SCOREBOARD_BYPASS_EN
        if (bus.iWbEn) begin
            pending_eff[bus.iWbAddr] = 1'b0;
        end
`endif
        raw0       = bus.iSrc0En && pending_eff[bus.iSrc0Addr];
        raw1       = bus.iSrc1En && pending_eff[bus.iSrc1Addr];
        waw        = bus.iWriteEn && pending_eff[bus.iWriteAddr];
        structural = bus.iMduOp && (mdu_cnt_q != 4'd0);
        stall      = iRst_n && bus.iValid && (raw0 || raw1 || waw || structural);
        issue      = iRst_n && bus.iValid && !stall && !bus.iFlush;
    end

    // Next-state: writeback clear, then flush clear, then issue set (set wins)
    always_comb begin
        pending_d = pending_q;
        if (bus.iWbEn) begin
            pending_d[bus.iWbAddr] = 1'b0;
        end
        if (bus.iFlush) begin
            if (h0_valid_q) pending_d[h0_addr_q] = 1'b0;
            if (h1_valid_q) pending_d[h1_addr_q] = 1'b0;
        end
        if (issue && bus.iWriteEn) begin
            pending_d[bus.iWriteAddr] = 1'b1;
        end

        h0_valid_d = issue && bus.iWriteEn;
        h0_addr_d  = bus.iWriteAddr;
        h1_valid_d = h0_valid_q;
        h1_addr_d  = h0_addr_q;
        if (bus.iFlush) begin
            h0_valid_d = 1'b0;
            h1_valid_d = 1'b0;
        end

        // A flush does not cancel an MDU op already counting down
        mdu_cnt_d = mdu_cnt_q;
        if (issue && bus.iMduOp) begin
            mdu_cnt_d = MDU_LOAD;
        end else if (mdu_cnt_q != 4'd0) begin
            mdu_cnt_d = mdu_cnt_q - 4'd1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            pending_q  <= '0;
            mdu_cnt_q  <= '0;
            h0_valid_q <= 1'b0;
            h0_addr_q  <= '0;
            h1_valid_q <= 1'b0;
            h1_addr_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            mdu_cnt_q  <= mdu_cnt_d;
            h0_valid_q <= h0_valid_d;
            h0_addr_q  <= h0_addr_d;
            h1_valid_q <= h1_valid_d;
            h1_addr_q  <= h1_addr_d;
        end
    end

    assign bus.oStall   = stall;
    assign bus.oIssue   = issue;
    assign bus.oMduBusy = iRst_n && (mdu_cnt_q != 4'd0);
    assign bus.oPending = iRst_n ? pending_q : 32'h0;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Bench for decode_scoreboard: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decode_scoreboard;

    localparam int MDU_LAT = 4;
`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    decode_scoreboard_if sb_if ();

    decode_scoreboard #(.MDU_LATENCY(MDU_LAT)) dut (
        .iClk   (clk),
        .iRst_n (rst_n),
        .bus    (sb_if)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.iValid     = 1'b0;
        sb_if.iSrc0Addr  = 5'd0;
        sb_if.iSrc1Addr  = 5'd0;
        sb_if.iSrc0En    = 1'b0;
        sb_if.iSrc1En    = 1'b0;
        sb_if.iWriteAddr = 5'd0;
        sb_if.iWriteEn   = 1'b0;
        sb_if.iMduOp     = 1'b0;
        sb_if.iWbAddr    = 5'd0;
        sb_if.iWbEn      = 1'b0;
        sb_if.iFlush     = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic put_write(input int r, input bit mdu);
        idle();
        sb_if.iValid     = 1'b1;
        sb_if.iWriteAddr = 5'(r);
        sb_if.iWriteEn   = 1'b1;
        sb_if.iMduOp     = mdu;
    endtask

    // Behavioural model: a set of outstanding destinations, the list of the
    // last two issues (-1 = issue without a write), and the cycle of the
    // last MDU issue.
    bit m_pend[32];
    int hist_q[$];
    int cyc;
    int last_mdu;

    function automatic bit pend_eff(input int r);
        if (BYPASS && sb_if.iWbEn && int'(sb_if.iWbAddr) == r) return 1'b0;
        return m_pend[r];
    endfunction

    function automatic logic [31:0] pend_word();
        logic [31:0] w;
        for (int i = 0; i < 32; i++) w[i] = m_pend[i];
        return w;
    endfunction

    // Scoreboard: compare every cycle, then advance the model past the edge
    bit e_busy, e_stall, e_issue;
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_stall",   {31'd0, sb_if.oStall},   32'd0);
            check("rst_issue",   {31'd0, sb_if.oIssue},   32'd0);
            check("rst_busy",    {31'd0, sb_if.oMduBusy}, 32'd0);
            check("rst_pending", sb_if.oPending,          32'd0);
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
            hist_q   = '{-1, -1};
            cyc      = 0;
            last_mdu = -1000;
        end else begin
            e_busy  = (cyc - last_mdu >= 1) && (cyc - last_mdu <= MDU_LAT);
            e_stall = sb_if.iValid && (
                      (sb_if.iSrc0En  && pend_eff(int'(sb_if.iSrc0Addr))) ||
                      (sb_if.iSrc1En  && pend_eff(int'(sb_if.iSrc1Addr))) ||
                      (sb_if.iWriteEn && pend_eff(int'(sb_if.iWriteAddr))) ||
                      (sb_if.iMduOp   && e_busy));
            e_issue = sb_if.iValid && !e_stall && !sb_if.iFlush;
            check("stall",   {31'd0, sb_if.oStall},   {31'd0, e_stall});
            check("issue",   {31'd0, sb_if.oIssue},   {31'd0, e_issue});
            check("busy",    {31'd0, sb_if.oMduBusy}, {31'd0, e_busy});
            check("pending", sb_if.oPending,          pend_word());
            if (sb_if.iWbEn) m_pend[sb_if.iWbAddr] = 1'b0;
            if (sb_if.iFlush) begin
                foreach (hist_q[i]) if (hist_q[i] >= 0) m_pend[hist_q[i]] = 1'b0;
            end
            if (e_issue && sb_if.iWriteEn) m_pend[sb_if.iWriteAddr] = 1'b1;
            if (sb_if.iFlush) begin
                hist_q = '{-1, -1};
            end else begin
                hist_q.push_front((e_issue && sb_if.iWriteEn) ? int'(sb_if.iWriteAddr) : -1);
                hist_q = hist_q[0:1];
            end
            if (e_issue && sb_if.iMduOp) last_mdu = cyc;
            cyc++;
        end
    end

    int stalls, issue_k, busy_cnt;

    initial begin
        idle();
        do_reset();

        // Independent writers r1, r2, r3 back to back
        for (int r = 1; r <= 3; r++) begin
            put_write(r, 1'b0);
            #1;
            check("indep_no_stall", {31'd0, sb_if.oStall}, 32'd0);
            tick();
        end
        idle();
        #1;
        check("indep_pending", sb_if.oPending, 32'h0000_000E);
        tick();

        // Load-use: write r5 at cycle 0, writeback at cycle 3, reader from cycle 1
        do_reset();
        put_write(5, 1'b0);
        tick();
        stalls  = 0;
        issue_k = -1;
        for (int k = 1; k <= 8 && issue_k < 0; k++) begin
            idle();
            sb_if.iValid    = 1'b1;
            sb_if.iSrc0Addr = 5'd5;
            sb_if.iSrc0En   = 1'b1;
            sb_if.iWbAddr   = 5'd5;
            sb_if.iWbEn     = (k == 3);
            #1;
            if (sb_if.oStall) stalls++;
            if (sb_if.oIssue) issue_k = k;
            tick();
        end
        check("loaduse_stalls", 32'(stalls),  BYPASS ? 32'd2 : 32'd3);
        check("loaduse_issue",  32'(issue_k), BYPASS ? 32'd3 : 32'd4);

        // Two MDU ops: counter holds non-zero for cycles 1..4 after the first
        do_reset();
        put_write(10, 1'b1);
        tick();
        stalls   = 0;
        issue_k  = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 10 && issue_k < 0; k++) begin
            put_write(11, 1'b1);
            #1;
            if (sb_if.oMduBusy) busy_cnt++;
            if (sb_if.oStall) stalls++;
            if (sb_if.oIssue) issue_k = k;
            tick();
        end
        check("mdu_busy_cycles", 32'(busy_cnt), 32'(MDU_LAT));
        check("mdu_stalls",      32'(stalls),   32'(MDU_LAT));
        check("mdu_issue",       32'(issue_k),  32'(MDU_LAT + 1));

        // Flush retracts the two youngest writers, keeps older r6
        do_reset();
        put_write(6, 1'b0);
        tick();
        put_write(7, 1'b0);
        tick();
        put_write(8, 1'b0);
        tick();
        put_write(10, 1'b0);
        sb_if.iFlush = 1'b1;
        #1;
        check("flush_no_issue", {31'd0, sb_if.oIssue}, 32'd0);
        tick();
        idle();
        #1;
        check("flush_pending", sb_if.oPending, 32'h0000_0040);
        tick();

        // Writeback of r9 and a new r9 writer in the same cycle: set wins
        do_reset();
        put_write(9, 1'b0);
        sb_if.iWbAddr = 5'd9;
        sb_if.iWbEn   = 1'b1;
        tick();
        idle();
        #1;
        check("setwins_pending", sb_if.oPending, 32'h0000_0200);
        tick();

        // Fill every pending bit, leave MDU count at 3, then reset mid-flight
        do_reset();
        for (int r = 0; r < 32; r++) begin
            put_write(r, r == 31);
            tick();
        end
        idle();
        tick();
        #1;
        check("full_pending", sb_if.oPending, 32'hFFFF_FFFF);
        check("full_busy",    {31'd0, sb_if.oMduBusy}, 32'd1);
        idle();
        sb_if.iValid    = 1'b1;
        sb_if.iSrc0Addr = 5'd31;
        sb_if.iSrc0En   = 1'b1;
        sb_if.iMduOp    = 1'b1;
        rst_n = 1'b0;
        #1;
        check("midrst_stall",   {31'd0, sb_if.oStall},   32'd0);
        check("midrst_issue",   {31'd0, sb_if.oIssue},   32'd0);
        check("midrst_busy",    {31'd0, sb_if.oMduBusy}, 32'd0);
        check("midrst_pending", sb_if.oPending,          32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("postrst_issue", {31'd0, sb_if.oIssue}, 32'd1);
        check("postrst_stall", {31'd0, sb_if.oStall}, 32'd0);
        tick();

        // Randomized traffic over a small register window to force hazards
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            sb_if.iValid     = ($urandom_range(0, 3) != 0);
            sb_if.iSrc0Addr  = 5'($urandom_range(0, 7));
            sb_if.iSrc1Addr  = 5'($urandom_range(0, 7));
            sb_if.iSrc0En    = 1'($urandom_range(0, 1));
            sb_if.iSrc1En    = 1'($urandom_range(0, 1));
            sb_if.iWriteAddr = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                           : 5'($urandom_range(0, 7));
            sb_if.iWriteEn   = ($urandom_range(0, 3) != 0);
            sb_if.iMduOp     = ($urandom_range(0, 5) == 0);
            sb_if.iWbAddr    = 5'($urandom_range(0, 7));
            sb_if.iWbEn      = 1'($urandom_range(0, 1));
            sb_if.iFlush     = ($urandom_range(0, 15) == 0);
            tick();
        end
        rst_n = 1'b1;
        idle();
        tick();
        tick();

        // Final report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
